// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared constants, FSM state type and the set-2 scancode to ASCII lookup
// used by the PS/2 scancode decoder.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} ps2_state_e;

  // Returns 0x00 for codes with no printable/control mapping.
  function automatic logic [7:0] ps2_ascii(input logic [7:0] sc, input logic upper);
    logic [7:0] c;
    case (sc)
      8'h1C: c = 8'h61;  8'h32: c = 8'h62;  8'h21: c = 8'h63;  8'h23: c = 8'h64;
      8'h24: c = 8'h65;  8'h2B: c = 8'h66;  8'h34: c = 8'h67;  8'h33: c = 8'h68;
      8'h43: c = 8'h69;  8'h3B: c = 8'h6A;  8'h42: c = 8'h6B;  8'h4B: c = 8'h6C;
      8'h3A: c = 8'h6D;  8'h31: c = 8'h6E;  8'h44: c = 8'h6F;  8'h4D: c = 8'h70;
      8'h15: c = 8'h71;  8'h2D: c = 8'h72;  8'h1B: c = 8'h73;  8'h2C: c = 8'h74;
      8'h3C: c = 8'h75;  8'h2A: c = 8'h76;  8'h1D: c = 8'h77;  8'h22: c = 8'h78;
      8'h35: c = 8'h79;  8'h1A: c = 8'h7A;
      8'h16: c = 8'h31;  8'h1E: c = 8'h32;  8'h26: c = 8'h33;  8'h25: c = 8'h34;
      8'h2E: c = 8'h35;  8'h36: c = 8'h36;  8'h3D: c = 8'h37;  8'h3E: c = 8'h38;
      8'h46: c = 8'h39;  8'h45: c = 8'h30;
      8'h29: c = 8'h20;  8'h5A: c = 8'h0D;  8'h66: c = 8'h08;
      default: c = 8'h00;
    endcase
    if (upper && c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Decoded-key stream from the decoder to its consumer (valid/ready).
interface ps2_key_if;
  logic       valid;
  logic       ready;
  logic [7:0] ascii;
  logic [7:0] scan;

  modport master (output valid, ascii, scan, input ready);
  modport slave  (input valid, ascii, scan, output ready);
endinterface

// File: rtl/ps2_scancode_decoder_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module ps2_key_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the empty flag masks stale
  // contents, and leaving it out keeps the array as plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scancode decoder: prefix FSM, modifier/held-key tracking and a
// key FIFO presenting decoded ASCII presses to the consumer.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        code_valid,
  input  logic [7:0]  code,
  ps2_key_if.master   key,
  output logic [7:0]  held_code,
  output logic [7:0]  make_count,
  output logic        shift_on,
  output logic        caps_on,
  output logic        overflow
);

  ps2_state_e state, state_d;
  logic       lshift, lshift_d, rshift, rshift_d, caps_d;
  logic [7:0] held_d, count_d, ascii;
  logic       push, pop, fifo_empty, fifo_full;
  logic [15:0] head;

  assign shift_on = lshift | rshift;
  assign ascii    = ps2_ascii(code, shift_on ^ caps_on);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      caps_on    <= 1'b0;
      held_code  <= 8'h00;
      make_count <= 8'h00;
      overflow   <= 1'b0;
    end else begin
      state      <= state_d;
      lshift     <= lshift_d;
      rshift     <= rshift_d;
      caps_on    <= caps_d;
      held_code  <= held_d;
      make_count <= count_d;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state;
    lshift_d = lshift;
    rshift_d = rshift;
    caps_d   = caps_on;
    held_d   = held_code;
    count_d  = make_count;
    push     = 1'b0;
    if (code_valid) begin
      unique case (state)
        IDLE: begin
          if (code == SC_EXT)        state_d = EXT;
          else if (code == SC_BREAK) state_d = BREAK;
          else begin
            if (code == SC_LSHIFT) lshift_d = 1'b1;
            if (code == SC_RSHIFT) rshift_d = 1'b1;
            // Typematic repeats of CapsLock keep held_code at 0x58 and do not toggle.
            if (code == SC_CAPS && held_code != SC_CAPS) caps_d = ~caps_on;
            if (code != held_code) begin
              count_d = make_count + 8'd1;
              held_d  = code;
            end
            push = (ascii != 8'h00);
          end
        end
        BREAK: begin
          state_d = IDLE;
          if (code == SC_LSHIFT) lshift_d = 1'b0;
          if (code == SC_RSHIFT) rshift_d = 1'b0;
          if (code == held_code) held_d = 8'h00;
        end
        EXT:       state_d = (code == SC_BREAK) ? EXT_BREAK : IDLE;
        EXT_BREAK: state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  assign pop = key.valid && key.ready;

  ps2_key_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data ({ascii, code}),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign key.valid = !fifo_empty;
  assign key.ascii = head[15:8];
  assign key.scan  = head[7:0];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench: stimulus queues expected key entries, a monitor pops and
// compares them on every accepted handshake.
module tb_ps2_scancode_decoder;
  import ps2_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;
  logic [7:0] held_code, make_count;
  logic       shift_on, caps_on, overflow;
  int         errors = 0;
  int         checks = 0;
  logic [15:0] exp_q[$];

  ps2_key_if key_bus ();

  ps2_scancode_decoder #(.FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .code_valid (code_valid),
    .code       (code),
    .key        (key_bus.master),
    .held_code  (held_code),
    .make_count (make_count),
    .shift_on   (shift_on),
    .caps_on    (caps_on),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expect_key(input logic [7:0] a, input logic [7:0] s);
    exp_q.push_back({a, s});
  endtask

  task automatic send(input logic [7:0] c);
    code_valid = 1'b1;
    code       = c;
    @(posedge clk); #1;
    code_valid = 1'b0;
    code       = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor samples on the falling edge, half a cycle clear of the handshake edge.
  always @(negedge clk) begin
    if (resetn && key_bus.valid && key_bus.ready) begin
      logic [15:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_key: got ascii=0x%0h scan=0x%0h, none expected",
                 key_bus.ascii, key_bus.scan);
      end else begin
        e = exp_q.pop_front();
        if ({key_bus.ascii, key_bus.scan} != e) begin
          errors++;
          $display("FAIL key_entry: got ascii=0x%0h scan=0x%0h expected ascii=0x%0h scan=0x%0h",
                   key_bus.ascii, key_bus.scan, e[15:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    key_bus.ready = 1'b1;
    #12;
    check("reset_key_valid", int'(key_bus.valid), 0);
    check("reset_held", int'(held_code), 0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    // Plain make, then its break.
    expect_key(8'h61, 8'h1C);
    send(8'h1C);
    send(SC_BREAK); send(8'h1C);
    check("t1_held", int'(held_code), 8'h00);
    check("t1_count", int'(make_count), 1);
    idle(3);
    check("t1_drained", exp_q.size(), 0);

    // Shift makes letters uppercase only while held.
    expect_key(8'h41, 8'h1C); expect_key(8'h61, 8'h1C);
    send(SC_LSHIFT);
    check("t2_shift_on", int'(shift_on), 1);
    send(8'h1C); send(SC_BREAK); send(8'h1C); send(SC_BREAK); send(SC_LSHIFT); send(8'h1C);
    check("t2_shift_off", int'(shift_on), 0);
    check("t2_count", int'(make_count), 4);
    idle(3);
    check("t2_drained", exp_q.size(), 0);

    // CapsLock toggling, Shift cancelling CapsLock, typematic CapsLock.
    expect_key(8'h41, 8'h1C); expect_key(8'h61, 8'h1C);
    send(SC_CAPS); send(SC_BREAK); send(SC_CAPS); send(8'h1C); send(SC_RSHIFT); send(8'h1C);
    check("t3_caps_on", int'(caps_on), 1);
    check("t3_rshift", int'(shift_on), 1);
    send(SC_BREAK); send(SC_RSHIFT);
    send(SC_CAPS); send(SC_CAPS);
    check("t3_caps_typematic", int'(caps_on), 0);
    check("t3_count", int'(make_count), 9);
    send(SC_BREAK); send(SC_CAPS);
    check("t3_held_released", int'(held_code), 8'h00);
    idle(3);
    check("t3_drained", exp_q.size(), 0);

    // Extended make and break are ignored entirely.
    send(SC_EXT); send(8'h75);
    check("t4_state_after_ext", int'(dut.state), int'(IDLE));
    send(SC_EXT); send(SC_BREAK); send(8'h75);
    check("t4_state_after_extbrk", int'(dut.state), int'(IDLE));
    check("t4_count_unchanged", int'(make_count), 9);
    expect_key(8'h31, 8'h16);
    send(8'h16);
    check("t4_held", int'(held_code), 8'h16);
    idle(3);
    check("t4_drained", exp_q.size(), 0);

    // Consumer stalled: nine back-to-back makes, ninth dropped.
    key_bus.ready = 1'b0;
    expect_key(8'h61, 8'h1C); expect_key(8'h62, 8'h32); expect_key(8'h63, 8'h21);
    expect_key(8'h64, 8'h23); expect_key(8'h65, 8'h24); expect_key(8'h66, 8'h2B);
    expect_key(8'h67, 8'h34); expect_key(8'h68, 8'h33);
    send(8'h1C);
    check("t5_overflow_early", int'(overflow), 0);
    send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    send(8'h2B); send(8'h34); send(8'h33); send(8'h43);
    check("t5_overflow", int'(overflow), 1);
    check("t5_head_ascii", int'(key_bus.ascii), 8'h61);
    check("t5_count", int'(make_count), 8'h13);
    key_bus.ready = 1'b1;
    idle(12);
    check("t5_drained", exp_q.size(), 0);
    check("t5_empty_valid", int'(key_bus.valid), 0);
    check("t5_empty_ascii", int'(key_bus.ascii), 0);
    check("t5_overflow_sticky", int'(overflow), 1);

    // Asynchronous reset after a break prefix.
    send(SC_CAPS);
    check("t6_caps_before_reset", int'(caps_on), 1);
    send(SC_BREAK);
    #3 resetn = 1'b0;
    #1;
    check("t6_rst_valid", int'(key_bus.valid), 0);
    check("t6_rst_ascii", int'(key_bus.ascii), 0);
    check("t6_rst_scan", int'(key_bus.scan), 0);
    check("t6_rst_held", int'(held_code), 0);
    check("t6_rst_count", int'(make_count), 0);
    check("t6_rst_shift", int'(shift_on), 0);
    check("t6_rst_caps", int'(caps_on), 0);
    check("t6_rst_overflow", int'(overflow), 0);
    check("t6_rst_state", int'(dut.state), int'(IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    expect_key(8'h61, 8'h1C);
    send(8'h1C);
    check("t6_held_after", int'(held_code), 8'h1C);
    check("t6_count_after", int'(make_count), 1);
    idle(3);
    check("t6_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
